data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory responder for the MEM stage of the 5-stage MIPS pipeline.
//   It accepts load/store requests from the pipeline, models a fixed access latency,
//   and holds stall_o high until the access completes.
//   The pipeline freezes PC and all stage registers while stall_o=1.
//   On completion the block returns load data and pulses ack_o for one cycle.
// PARAMETERS
//   LATENCY     4    BUSY cycles per access; legal range 1..15
//   IDX_W       8    word-index width; memory holds 2**IDX_W 32-bit words
// PORTS
//   clk_i          in   1   clock; all state changes on rising edge
//   rst_i          in   1   asynchronous, active-high reset
//   MemRead_i      in   1   load request; held stable by pipeline while stall_o=1
//   MemWrite_i     in   1   store request; held stable while stall_o=1
//   addr_i         in   32  byte address (ALU result)
//   data_i         in   32  store data
//   data_o         out  32  load data, registered
//   stall_o        out  1   pipeline stall
//   ack_o          out  1   one-cycle completion pulse
//   access_cnt_o   out  32  number of completed accesses
// BEHAVIOUR
//   - Reset values: state=IDLE, data_o=0, ack_o=0, access_cnt_o=0, cnt=0.
//     stall_o=0 while rst_i=1. The memory array is not reset.
//   - req = MemRead_i | MemWrite_i.
//     If both are set, the access is a store (write wins).
//   - Index = addr_i[IDX_W+1:2]. addr_i[1:0] and upper bits are ignored, so high addresses wrap.
//   - stall_o = (IDLE & req) | BUSY.
//     It is combinational so the request cycle itself stalls.
//   - IDLE: if req, latch index, data_i and op, load cnt=LATENCY-1, go to BUSY.
//     Otherwise stay in IDLE.
//   - BUSY: if cnt!=0, cnt-- and stay.
//     If cnt==0, perform the access:
//       store: mem[idx] <= data.
//       load: data_o <= mem[idx].
//     Then set ack_o=1, access_cnt_o++ (wraps at 2**32), go to DONE.
//   - DONE: stall_o=0, ack_o=1, then go to IDLE unconditionally.
//     The request still visible in DONE is the completing one; it must NOT be re-accepted.
//   - Timing: request first seen in IDLE at cycle T.
//     stall_o=1 for cycles T..T+LATENCY (LATENCY+1 cycles).
//     ack_o and valid data_o at cycle T+LATENCY+1.
//     Earliest acceptance of the next request is T+LATENCY+2.
//   - data_o holds its last load value across stores and idle cycles.
//   - Request inputs changing during BUSY are ignored; the latched values are used.
//   - Reset mid-BUSY: abort to IDLE. A pending store is NOT performed; memory is unchanged.
//   - Store then load to the same index: the load returns the stored value (no bypass needed).
// TESTING
//   1. LATENCY=4, store 0xDEADBEEF @0x10.
//      -> stall_o high 5 cycles; ack at T+5; access_cnt_o=1.
//   2. Load @0x10 after test 1.
//      -> stall 5 cycles; data_o=0xDEADBEEF at ack; data_o held afterwards.
//   3. Back-to-back load/store with request lines held through DONE.
//      -> exactly one access per request; second request accepted at T+6; no double count.
//   4. Store 0x1 @0x0 then store 0x2 @(4<<IDX_W).
//      -> the second store wraps; a load @0x0 returns 0x2.
//   5. rst_i asserted in the 2nd BUSY cycle of store 0x55 @0x20.
//      -> state IDLE, stall_o=0, data_o=0, access_cnt_o=0; a later load @0x20 returns the old value.
//   6. LATENCY=1, MemRead_i=MemWrite_i=1, data 0x7 @0x8.
//      -> stall 2 cycles; the access is treated as a store; a later load returns 0x7.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store,
// stalls the pipeline for a fixed latency, then returns data with a one-cycle ack.
module data_mem_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] access_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             store_q;
  logic             req;
  logic             accept;
  logic             access;
  logic             stall_raw;
  logic [31:0]      mem [2**IDX_W];

  // Word index drops the byte offset and everything above the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  assign req    = MemRead_i | MemWrite_i;
  assign accept = (state == IDLE) && req;
  assign access = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE always returns to IDLE so a request still held there is not re-accepted.
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_o = stall_raw & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt          <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      store_q      <= 1'b0;
      data_o       <= 32'd0;
      ack_o        <= 1'b0;
      access_cnt_o <= 32'd0;
    end else begin
      ack_o <= access;
      if (accept) begin
        cnt     <= CNT_INIT;
        idx_q   <= addr_i[IDX_W+1:2];
        wdata_q <= data_i;
        store_q <= MemWrite_i;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        if (!store_q) data_o <= mem[idx_q];
        access_cnt_o <= access_cnt_o + 32'd1;
      end
    end
  end

  // Array has no reset; an aborted access never reaches the write enable.
  always_ff @(posedge clk_i) begin
    if (access && store_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (latency 4 and 1) driven by directed and
// random transactions, compared against an address-level memory model.
module tb_data_mem_responder;

  localparam int IDX_W = 8;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic        clk;
  logic        rst;
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        stall     [2];
  logic        ack       [2];
  logic [31:0] acc_cnt   [2];

  int vectors;
  int miscompares;

  logic [31:0] model_mem [int];
  logic [31:0] exp_data  [2];
  logic [31:0] exp_cnt   [2];
  int          written   [$];

  data_mem_responder #(.LATENCY(LAT_A), .IDX_W(IDX_W)) dut_a (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mem_read[0]), .MemWrite_i(mem_write[0]),
    .addr_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]), .stall_o(stall[0]),
    .ack_o(ack[0]), .access_cnt_o(acc_cnt[0])
  );

  data_mem_responder #(.LATENCY(LAT_B), .IDX_W(IDX_W)) dut_b (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mem_read[1]), .MemWrite_i(mem_write[1]),
    .addr_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]), .stall_o(stall[1]),
    .ack_o(ack[1]), .access_cnt_o(acc_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int key_of(input int d, input logic [31:0] a);
    return d * 65536 + int'((a / 4) % (1 << IDX_W));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] dat);
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = dat;
  endtask

  // Cycles with no request: nothing stalls, no ack, outputs hold.
  task automatic idle_check(input int d, input int n);
    drive(d, 1'b0, 1'b0, $urandom, $urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", 32'(stall[d]), 32'd0);
      check("idle_ack", 32'(ack[d]), 32'd0);
      check("idle_data", rdata[d], exp_data[d]);
      check("idle_cnt", acc_cnt[d], exp_cnt[d]);
      @(posedge clk); #1;
    end
  endtask

  // One full access starting in the current (IDLE) cycle; returns at DONE+1.
  task automatic apply_stimulus(input int d, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] dat,
                                input bit hold_done);
    int lat;
    int key;
    lat = (d == 0) ? LAT_A : LAT_B;
    key = key_of(d, a);
    drive(d, rd, wr, a, dat);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("busy_stall", 32'(stall[d]), 32'd1);
      check("busy_ack", 32'(ack[d]), 32'd0);
      @(posedge clk); #1;
      if (k < lat) begin
        addr[d]  = $urandom;
        wdata[d] = $urandom;
      end else if (hold_done) begin
        drive(d, rd, wr, a, dat);
      end else begin
        drive(d, 1'b0, 1'b0, $urandom, $urandom);
      end
    end
    if (wr) model_mem[key] = dat;
    else    exp_data[d] = model_mem[key];
    exp_cnt[d] = exp_cnt[d] + 32'd1;
    check_output(d);
    @(posedge clk); #1;
  endtask

  task automatic check_output(input int d);
    @(negedge clk);
    check("done_stall", 32'(stall[d]), 32'd0);
    check("done_ack", 32'(ack[d]), 32'd1);
    check("done_data", rdata[d], exp_data[d]);
    check("done_cnt", acc_cnt[d], exp_cnt[d]);
  endtask

  initial begin
    int op;
    int pick;
    bit hold;
    bit prev_hold;
    logic [31:0] ra;
    vectors     = 0;
    miscompares = 0;
    for (int d = 0; d < 2; d++) begin
      exp_data[d] = 32'd0;
      exp_cnt[d]  = 32'd0;
    end

    // Reset with a request pending: stall must stay low.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h8, 32'h0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_stall", 32'(stall[d]), 32'd0);
      check("rst_ack", 32'(ack[d]), 32'd0);
      check("rst_data", rdata[d], 32'd0);
      check("rst_cnt", acc_cnt[d], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_check(0, 2);

    // Store then load the same word.
    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    idle_check(0, 1);
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("load_deadbeef", rdata[0], 32'hDEADBEEF);
    idle_check(0, 2);

    // Back-to-back with request held through DONE.
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    apply_stimulus(0, 1'b0, 1'b1, 32'h44, 32'hCAFE0001, 1'b0);
    idle_check(0, 1);

    // Index wrap: 4<<IDX_W aliases word 0.
    apply_stimulus(0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
    apply_stimulus(0, 1'b0, 1'b1, 32'(4 << IDX_W), 32'h2, 1'b0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("wrap_load", rdata[0], 32'h2);

    written.push_back(32'h10);
    written.push_back(32'h44);
    written.push_back(32'h0);

    // Random mix of loads/stores, some held through DONE.
    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!prev_hold && ($urandom % 3 == 0)) idle_check(0, 1 + int'($urandom % 3));
      op   = int'($urandom_range(0, 2));
      hold = (i != 39) && ($urandom % 2 == 1);
      if (op == 0) begin
        pick = int'($urandom_range(0, written.size() - 1));
        ra   = written[pick] + 32'($urandom_range(0, 3)) + ($urandom << (IDX_W + 2));
        apply_stimulus(0, 1'b1, 1'b0, ra, $urandom, hold);
      end else begin
        ra = $urandom;
        written.push_back(int'(ra & 32'(((1 << IDX_W) - 1) << 2)));
        apply_stimulus(0, (op == 2), 1'b1, ra, $urandom, hold);
      end
      prev_hold = hold;
    end
    idle_check(0, 1);

    // Reset in the 2nd BUSY cycle of a store aborts it.
    apply_stimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_data[d] = 32'd0;
      exp_cnt[d]  = 32'd0;
    end
    @(negedge clk);
    check("abort_stall", 32'(stall[0]), 32'd0);
    check("abort_data", rdata[0], 32'd0);
    check("abort_cnt", acc_cnt[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(0, 2);
    apply_stimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("abort_old_value", rdata[0], 32'h12345678);

    // Latency 1, read+write together is a store.
    idle_check(1, 1);
    apply_stimulus(1, 1'b1, 1'b1, 32'h8, 32'h7, 1'b0);
    apply_stimulus(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
    check("lat1_load", rdata[1], 32'h7);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      apply_stimulus(1, 1'b0, 1'b1, ra, $urandom, 1'b0);
      apply_stimulus(1, 1'b1, 1'b0, ra ^ (32'd1 << (IDX_W + 2 + (i % 20))), 32'h0, 1'b0);
    end
    idle_check(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
